// File: rtl/host_bus_decoder_if.sv
// Host bus between the core and host_bus_decoder; signal names are from the decoder's side.
// HOST_BUS_FAULT_EN adds the unmapped-write fault clear/status signals.
interface host_bus_decoder_if #(
   parameter int P_slaves    = 4,
   parameter int P_addr_bits = 16
);
   logic [P_addr_bits-1:0] I_addr;
   logic                   I_rdwr;
   logic                   I_phy2;
   logic [7:0]             I_wr_data;
   logic [7:0]             O_rd_data;
   logic                   O_ready;
   logic [P_slaves-1:0]    O_select;
   logic [P_slaves-1:0]    O_wren;
   logic [8*P_slaves-1:0]  I_slave_data;
   logic [7:0]             O_open_bus;
`ifdef HOST_BUS_FAULT_EN
   logic                   I_fault_clear;
   logic                   O_fault;
   logic [P_addr_bits-1:0] O_fault_addr;
`endif

   modport master (
      output I_addr, I_rdwr, I_phy2, I_wr_data, I_slave_data,
`ifdef HOST_BUS_FAULT_EN
      output I_fault_clear,
      input  O_fault, O_fault_addr,
`endif
      input  O_rd_data, O_ready, O_select, O_wren, O_open_bus
   );

   modport slave (
      input  I_addr, I_rdwr, I_phy2, I_wr_data, I_slave_data,
`ifdef HOST_BUS_FAULT_EN
      input  I_fault_clear,
      output O_fault, O_fault_addr,
`endif
      output O_rd_data, O_ready, O_select, O_wren, O_open_bus
   );
endinterface

// File: rtl/host_bus_decoder.sv
// Table-driven host page decoder with per-slave wait states and open-bus latch; decode/read return are zero latency,
// O_ready is held low for the slave's wait count after each access start. HOST_BUS_FAULT_EN adds sticky unmapped-write fault capture.
module host_bus_decoder #(
   parameter int                                  P_slaves    = 4,
   parameter int                                  P_addr_bits = 16,
   parameter int                                  P_page_bits = 4,
   parameter logic [(4 << P_page_bits)-1:0]       P_page_map  = 64'h2222_2222_2222_1100,
   parameter int                                  P_wait_bits = 3,
   parameter logic [P_slaves*P_wait_bits-1:0]     P_wait_map  = '0
) (
   input logic                I_clock,
   input logic                I_reset,
   host_bus_decoder_if.slave  bus
);

   if (P_slaves < 1 || P_slaves > 7 || P_page_bits > P_addr_bits) begin : g_bad_param
      $error("host_bus_decoder: P_slaves must be 1..7 and P_page_bits <= P_addr_bits");
   end

   logic [P_page_bits-1:0] page;
   logic [3:0]             idx;
   logic [P_slaves-1:0]    sel;
   logic [P_wait_bits-1:0] wait_cycles;
   logic [7:0]             rd_data;
   logic [P_wait_bits-1:0] wcnt;
   logic                   phy2_d;
   logic [7:0]             latch;
   logic                   start;
   logic                   ready;

   assign page = bus.I_addr[P_addr_bits-1 -: P_page_bits];
   assign idx  = P_page_map[{page, 2'b00} +: 4];

   // Unmapped pages match no slave: no select, zero waits, open-bus read data.
   always_comb begin
      sel         = '0;
      wait_cycles = '0;
      rd_data     = latch;
      for (int i = 0; i < P_slaves; i++) begin
         if (idx == 4'(i)) begin
            sel[i]      = 1'b1;
            wait_cycles = P_wait_map[i*P_wait_bits +: P_wait_bits];
            rd_data     = bus.I_slave_data[i*8 +: 8];
         end
      end
   end

   assign start = bus.I_phy2 & ~phy2_d;
   // Reset forces ready and masks writes so an aborted wait never completes its write.
   assign ready = I_reset | (start ? (wait_cycles == '0) : (wcnt == '0));

   assign bus.O_select   = sel;
   assign bus.O_rd_data  = rd_data;
   assign bus.O_ready    = ready;
   assign bus.O_wren     = {P_slaves{bus.I_phy2 & ~bus.I_rdwr & ready & ~I_reset}} & sel;
   assign bus.O_open_bus = latch;

   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         phy2_d <= 1'b0;
         wcnt   <= '0;
         latch  <= 8'hFF;
      end else begin
         phy2_d <= bus.I_phy2;
         if (start)
            wcnt <= (wait_cycles != '0) ? wait_cycles - P_wait_bits'(1) : '0;
         else if (wcnt != '0)
            wcnt <= wcnt - P_wait_bits'(1);
         if (bus.I_phy2 & ready)
            latch <= bus.I_rdwr ? rd_data : bus.I_wr_data;
      end
   end

`ifdef HOST_BUS_FAULT_EN
   logic                   fault;
   logic [P_addr_bits-1:0] fault_addr;
   logic                   fault_ev;

   assign fault_ev         = bus.I_phy2 & ~bus.I_rdwr & ready & (sel == '0);
   assign bus.O_fault      = fault;
   assign bus.O_fault_addr = fault_addr;

   // A fault coinciding with clear re-arms with the new address.
   always_ff @(posedge I_clock or posedge I_reset) begin
      if (I_reset) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end else if (fault_ev) begin
         if (!fault || bus.I_fault_clear) begin
            fault      <= 1'b1;
            fault_addr <= bus.I_addr;
         end
      end else if (bus.I_fault_clear) begin
         fault      <= 1'b0;
         fault_addr <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_host_bus_decoder.sv
// Directed bench: dut_a uses the default page map, dut_b an unmapped page F and wait states (slave2=3, slave3=5).
module tb_host_bus_decoder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   host_bus_decoder_if #(.P_slaves(4), .P_addr_bits(16)) bus_a ();
   host_bus_decoder_if #(.P_slaves(4), .P_addr_bits(16)) bus_b ();

   host_bus_decoder dut_a (.I_clock(clk), .I_reset(rst), .bus(bus_a));

   host_bus_decoder #(
      .P_page_map (64'hF322_2222_2222_1100),
      .P_wait_map ({3'd5, 3'd3, 3'd0, 3'd0})
   ) dut_b (.I_clock(clk), .I_reset(rst), .bus(bus_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      else
         passed++;
   endtask

   task automatic idle();
      bus_a.I_phy2 = 1'b0;
      bus_b.I_phy2 = 1'b0;
   endtask

   task automatic test_reset();
      smp();
      chk("rst_ready_a", 32'(bus_a.O_ready), 32'h1);
      chk("rst_obus_a", 32'(bus_a.O_open_bus), 32'hFF);
      chk("rst_ready_b", 32'(bus_b.O_ready), 32'h1);
      chk("rst_obus_b", 32'(bus_b.O_open_bus), 32'hFF);
      chk("rst_wren_b", 32'(bus_b.O_wren), 32'h0);
`ifdef HOST_BUS_FAULT_EN
      chk("rst_fault", 32'(bus_b.O_fault), 32'h0);
`endif
      tick();
      rst = 1'b0;
   endtask

   task automatic test_default_map();
      tick();
      bus_a.I_addr = 16'h0123; bus_a.I_rdwr = 1'b0; bus_a.I_wr_data = 8'h5A; bus_a.I_phy2 = 1'b1;
      smp();
      chk("wr0123_wren", 32'(bus_a.O_wren), 32'h1);
      chk("wr0123_sel", 32'(bus_a.O_select), 32'h1);
      tick();
      idle();
      smp();
      chk("wr0123_wren_off", 32'(bus_a.O_wren), 32'h0);
      chk("wr0123_obus", 32'(bus_a.O_open_bus), 32'h5A);
      tick();
      bus_a.I_rdwr = 1'b1; bus_a.I_phy2 = 1'b1;
      smp();
      chk("rd0123_data", 32'(bus_a.O_rd_data), 32'h11);
      chk("rd0123_sel", 32'(bus_a.O_select), 32'h1);
      chk("rd0123_wren", 32'(bus_a.O_wren), 32'h0);
      tick();
      idle();
      bus_a.I_addr = 16'h2002;
      smp();
      chk("sel2002", 32'(bus_a.O_select), 32'h2);
      tick();
      bus_a.I_addr = 16'h8000;
      smp();
      chk("sel8000", 32'(bus_a.O_select), 32'h4);
      chk("rd8000_data", 32'(bus_a.O_rd_data), 32'h33);
   endtask

   task automatic test_back_to_back();
      logic [15:0] addrs [3];
      logic [7:0]  data  [3];
      addrs = '{16'h0000, 16'h2000, 16'h8000};
      data  = '{8'h11, 8'h22, 8'h33};
      tick();
      idle();
      tick();
      bus_a.I_rdwr = 1'b1;
      bus_a.I_phy2 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_a.I_addr = addrs[i];
         smp();
         chk("b2b_ready", 32'(bus_a.O_ready), 32'h1);
         chk("b2b_rd", 32'(bus_a.O_rd_data), 32'(data[i]));
         if (i > 0) chk("b2b_obus", 32'(bus_a.O_open_bus), 32'(data[i-1]));
         tick();
      end
      idle();
      smp();
      chk("b2b_obus_last", 32'(bus_a.O_open_bus), 32'h33);
   endtask

   task automatic test_wait_states();
      tick();
      bus_b.I_addr = 16'hC000; bus_b.I_rdwr = 1'b1; bus_b.I_phy2 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         smp();
         chk("rdC000_ready", 32'(bus_b.O_ready), (c == 3) ? 32'h1 : 32'h0);
         if (c < 3) chk("rdC000_obus_hold", 32'(bus_b.O_open_bus), 32'hFF);
         if (c < 3) tick();
      end
      chk("rdC000_data", 32'(bus_b.O_rd_data), 32'hC3);
      tick();
      idle();
      smp();
      chk("rdC000_obus", 32'(bus_b.O_open_bus), 32'hC3);
      tick();
      bus_b.I_rdwr = 1'b0; bus_b.I_wr_data = 8'h77; bus_b.I_phy2 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         smp();
         chk("wrC000_ready", 32'(bus_b.O_ready), (c == 3) ? 32'h1 : 32'h0);
         chk("wrC000_wren", 32'(bus_b.O_wren), (c == 3) ? 32'h4 : 32'h0);
         if (c < 3) tick();
      end
      tick();
      idle();
      smp();
      chk("wrC000_obus", 32'(bus_b.O_open_bus), 32'h77);
   endtask

   task automatic test_open_bus();
      tick();
      bus_b.I_addr = 16'h4000; bus_b.I_rdwr = 1'b0; bus_b.I_wr_data = 8'h3C; bus_b.I_phy2 = 1'b1;
      for (int c = 0; c < 4; c++) tick();
      idle();
      tick();
      bus_b.I_addr = 16'hF000; bus_b.I_rdwr = 1'b1; bus_b.I_phy2 = 1'b1;
      smp();
      chk("rdF000_ready", 32'(bus_b.O_ready), 32'h1);
      chk("rdF000_sel", 32'(bus_b.O_select), 32'h0);
      chk("rdF000_data", 32'(bus_b.O_rd_data), 32'h3C);
      tick();
      idle();
      smp();
      chk("rdF000_obus", 32'(bus_b.O_open_bus), 32'h3C);
      tick();
      bus_b.I_rdwr = 1'b0; bus_b.I_wr_data = 8'hE1; bus_b.I_phy2 = 1'b1;
      smp();
      chk("wrF000_wren", 32'(bus_b.O_wren), 32'h0);
      tick();
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus_b.I_rdwr = 1'b1; bus_b.I_phy2 = 1'b1;
      smp();
      chk("rdF000_after_rst", 32'(bus_b.O_rd_data), 32'hFF);
      tick();
      idle();
   endtask

   task automatic test_reset_mid_wait();
      tick();
      bus_b.I_addr = 16'hE000; bus_b.I_rdwr = 1'b0; bus_b.I_wr_data = 8'h99; bus_b.I_phy2 = 1'b1;
      smp();
      chk("midw_c0_ready", 32'(bus_b.O_ready), 32'h0);
      tick();
      smp();
      chk("midw_c1_ready", 32'(bus_b.O_ready), 32'h0);
      tick();
      #2;
      rst = 1'b1;
      #1;
      chk("midw_rst_ready", 32'(bus_b.O_ready), 32'h1);
      chk("midw_rst_wren", 32'(bus_b.O_wren), 32'h0);
      chk("midw_rst_obus", 32'(bus_b.O_open_bus), 32'hFF);
      smp();
      chk("midw_rst_wren2", 32'(bus_b.O_wren), 32'h0);
      tick();
      idle();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         smp();
         chk("midw_after_wren", 32'(bus_b.O_wren), 32'h0);
         chk("midw_after_ready", 32'(bus_b.O_ready), 32'h1);
         tick();
      end
      chk("midw_after_obus", 32'(bus_b.O_open_bus), 32'hFF);
   endtask

`ifdef HOST_BUS_FAULT_EN
   task automatic fault_write(input logic [15:0] addr, input logic clr);
      tick();
      bus_b.I_addr = addr; bus_b.I_rdwr = 1'b0; bus_b.I_wr_data = 8'h01;
      bus_b.I_phy2 = 1'b1; bus_b.I_fault_clear = clr;
      tick();
      idle();
      bus_b.I_fault_clear = 1'b0;
   endtask

   task automatic test_fault();
      fault_write(16'hF010, 1'b0);
      smp();
      chk("fault_set", 32'(bus_b.O_fault), 32'h1);
      chk("fault_addr1", 32'(bus_b.O_fault_addr), 32'hF010);
      fault_write(16'hF020, 1'b0);
      smp();
      chk("fault_sticky_addr", 32'(bus_b.O_fault_addr), 32'hF010);
      tick();
      bus_b.I_fault_clear = 1'b1;
      smp();
      chk("fault_clr_same", 32'(bus_b.O_fault), 32'h1);
      tick();
      bus_b.I_fault_clear = 1'b0;
      smp();
      chk("fault_clr_next", 32'(bus_b.O_fault), 32'h0);
      chk("fault_clr_addr", 32'(bus_b.O_fault_addr), 32'h0);
      fault_write(16'hF040, 1'b0);
      fault_write(16'hF050, 1'b1);
      smp();
      chk("fault_coinc", 32'(bus_b.O_fault), 32'h1);
      chk("fault_coinc_addr", 32'(bus_b.O_fault_addr), 32'hF050);
   endtask
`endif

   initial begin
      bus_a.I_addr = '0; bus_a.I_rdwr = 1'b1; bus_a.I_phy2 = 1'b0; bus_a.I_wr_data = '0;
      bus_b.I_addr = '0; bus_b.I_rdwr = 1'b1; bus_b.I_phy2 = 1'b0; bus_b.I_wr_data = '0;
      bus_a.I_slave_data = {8'h44, 8'h33, 8'h22, 8'h11};
      bus_b.I_slave_data = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
`ifdef HOST_BUS_FAULT_EN
      bus_a.I_fault_clear = 1'b0;
      bus_b.I_fault_clear = 1'b0;
`endif
      test_reset();
      test_default_map();
      test_back_to_back();
      test_wait_states();
      test_open_bus();
      test_reset_mid_wait();
`ifdef HOST_BUS_FAULT_EN
      test_fault();
`endif
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
